// File: rtl/xorpuf_pkg.sv
// ---------------------------------------------------------------------------
// xorpuf_pkg
// Shared definitions for the XOR-arbiter PUF evaluation controller:
//   - controller state enum
//   - settle counter width (SETTLE_W)
//   - default parameter constants
//   - helper returning how many evaluations one request needs
// Optional feature macro used by the users of this package:
//   XORPUF_MAJORITY_VOTE_EN - repeat each evaluation REPEAT times and vote.
// ---------------------------------------------------------------------------
package xorpuf_pkg;

  localparam int SETTLE_W   = 8;

  localparam int DEF_K      = 10;
  localparam int DEF_N      = 64;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_REPEAT = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } eval_state_e;

  // With voting every request is evaluated repeat_n times, otherwise once.
  function automatic int evals_per_request(input int repeat_n, input bit vote_en);
    return vote_en ? repeat_n : 1;
  endfunction

endpackage

// File: rtl/xorpuf_vote_acc.sv
// ---------------------------------------------------------------------------
// xorpuf_vote_acc
// One ones-counter per response bit for majority voting across repeated
// evaluations of the same challenge.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear        - zero all counters (start of a new request)
//   inc          - add the current sample bits into the counters
//   bits[M]      - sampled response bits
//   result[M]    - majority decision per bit: 1 iff count*2 > REPEAT
// ---------------------------------------------------------------------------
module xorpuf_vote_acc #(
  parameter int M      = 9,
  parameter int CNT_W  = 3,
  parameter int REPEAT = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [M-1:0] bits,
  output logic [M-1:0] result
);

  localparam logic [CNT_W:0] THRESH = (CNT_W+1)'(REPEAT);

  logic [CNT_W-1:0] cnt [M];

  // Counters are sized to hold REPEAT, so they never wrap within a request;
  // clear wins over inc because a new request restarts the vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < M; i++) cnt[i] <= '0;
    end else if (inc) begin
      for (int i = 0; i < M; i++) cnt[i] <= cnt[i] + CNT_W'(bits[i]);
    end
  end

  // Doubling the count avoids a division and keeps odd REPEAT exact.
  always_comb begin
    result = '0;
    for (int i = 0; i < M; i++) result[i] = ({cnt[i], 1'b0} > THRESH);
  end

endmodule

// File: rtl/xorpuf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// xorpuf_eval_ctrl
// Sequences evaluations of a K-chain XOR arbiter PUF: accepts a challenge,
// drives it to the chains, pulses launch, waits SETTLE cycles, samples the
// XOR network and returns the response (optionally majority-voted).
// Optional feature macro: XORPUF_MAJORITY_VOTE_EN
//   defined   - each request is evaluated REPEAT times, bits majority-voted
//   undefined - single evaluation, response is the one sample
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - challenge request handshake
//   req_chal[N]           - challenge to evaluate
//   puf_chal[N]           - challenge held on all chains until next accept
//   puf_launch            - one-cycle launch pulse
//   puf_resp[M]           - XOR output network result
//   out_valid/out_ready   - response handshake
//   out_resp[M]           - final response, zero outside DONE
//   busy                  - controller not idle
// ---------------------------------------------------------------------------
module xorpuf_eval_ctrl
  import xorpuf_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int M      = K - 1,
  parameter int N      = DEF_N,
  parameter int SETTLE = DEF_SETTLE,
  parameter int REPEAT = DEF_REPEAT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_chal,
  output logic [N-1:0] puf_chal,
  output logic         puf_launch,
  input  logic [M-1:0] puf_resp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_resp,
  output logic         busy
);

`ifdef XORPUF_MAJORITY_VOTE_EN
  localparam bit VOTE_EN = 1'b1;
`else
  localparam bit VOTE_EN = 1'b0;
`endif

  localparam int                  EVALS       = evals_per_request(REPEAT, VOTE_EN);
  localparam int                  EVAL_W      = $clog2(REPEAT + 1);
  localparam logic [EVAL_W-1:0]   EVAL_LAST   = EVAL_W'(EVALS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  // Out-of-range parameters are caught at elaboration rather than producing
  // a controller whose counters could wrap.
  if (SETTLE < 1 || SETTLE > 255 || REPEAT < 1 || REPEAT > 15 ||
      (REPEAT % 2) == 0 || M < 1 || M > K || N < 1) begin : g_bad_param
    $error("xorpuf_eval_ctrl: illegal parameter combination");
  end

  eval_state_e         state;
  eval_state_e         state_nxt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [EVAL_W-1:0]   eval_cnt;
  logic                accept;
  logic                sample_now;
  logic                last_eval;
  logic [M-1:0]        resp_final;

  assign accept     = (state == ST_IDLE) && req_valid;
  assign sample_now = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
  assign last_eval  = (eval_cnt == EVAL_LAST);

  // State register; reset aborts any evaluation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore outputs. DONE does not accept a new request in the
  // same cycle as the response handshake.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    puf_launch = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        puf_launch = 1'b1;
        state_nxt  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (sample_now) state_nxt = last_eval ? ST_DONE : ST_LAUNCH;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The challenge is captured once per request and held through every
  // repeated evaluation and beyond, until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      puf_chal <= '0;
    else if (accept) puf_chal <= req_chal;
  end

  // Settle counter restarts on each launch; the evaluation counter advances
  // once per sample and is cleared per request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      eval_cnt   <= '0;
    end else if (accept) begin
      settle_cnt <= '0;
      eval_cnt   <= '0;
    end else if (state == ST_LAUNCH) begin
      settle_cnt <= '0;
    end else if (sample_now) begin
      eval_cnt   <= eval_cnt + EVAL_W'(1);
    end else if (state == ST_SETTLE) begin
      settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

`ifdef XORPUF_MAJORITY_VOTE_EN
  xorpuf_vote_acc #(
    .M      (M),
    .CNT_W  (EVAL_W),
    .REPEAT (REPEAT)
  ) u_vote_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .inc    (sample_now),
    .bits   (puf_resp),
    .result (resp_final)
  );
`else
  logic [M-1:0] resp_q;

  // Single evaluation: keep the one sample taken at the end of settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          resp_q <= '0;
    else if (accept)     resp_q <= '0;
    else if (sample_now) resp_q <= puf_resp;
  end

  assign resp_final = resp_q;
`endif

  // The response is only presented in DONE, where its source is frozen.
  assign out_resp = (state == ST_DONE) ? resp_final : '0;

endmodule
